// File: rtl/key_evt_pkg.sv
// key_evt_pkg: shared event/state types for the key event scheduler
package key_evt_pkg;
  localparam int EVT_KEY_W = 8;
  typedef enum logic [1:0] {EVT_PRESS, EVT_LONG, EVT_REPEAT, EVT_RELEASE} evt_type_t;
  typedef enum logic [1:0] {KS_IDLE, KS_HELD, KS_LONG} key_state_t;
  typedef struct packed {
    logic [EVT_KEY_W-1:0] key;
    evt_type_t            typ;
  } evt_t;
endpackage

// File: rtl/key_evt_fifo.sv
// key_evt_fifo: small registered FIFO with valid/ready pop; push accepted when full if a pop happens
module key_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         push_rdy_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic pop, push;
  assign valid_o = cnt_q != '0;
  assign data_o = mem_q[rp_q];
  assign pop = valid_o & ready_i;
  assign push_rdy_o = (cnt_q != (AW+1)'(DEPTH)) | pop;
  assign push = push_i & push_rdy_o;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push) mem_q[wp_q] <= data_i;
      wp_q <= wp_q + AW'(push);
      rp_q <= rp_q + AW'(pop);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/key_event_scheduler.sv
// key_event_scheduler: per-key press/long/repeat FSMs arbitrated round-robin into one event stream
module key_event_scheduler
  import key_evt_pkg::*;
#(
  parameter int N_KEYS = 4,
  parameter int LONG_CYC = 50_000_000,
  parameter int REPEAT_CYC = 10_000_000,
  parameter int FIFO_DEPTH = 4,
  localparam int KW = N_KEYS > 1 ? $clog2(N_KEYS) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_KEYS-1:0] i_pos,
  input  logic [N_KEYS-1:0] i_neg,
  input  logic              i_enable,
  output logic              o_evt_valid,
  output logic [KW-1:0]     o_evt_key,
  output logic [1:0]        o_evt_type,
  input  logic              i_evt_ready,
  output logic              o_overflow,
  input  logic              i_clr_ovf
);
  localparam int TMAX = LONG_CYC > REPEAT_CYC ? LONG_CYC : REPEAT_CYC;
  localparam int TW = TMAX > 1 ? $clog2(TMAX) : 1;
  logic [N_KEYS-1:0][3:0] pend_q, pend_d, set_e, clr_e;
  logic [KW-1:0] rr_q, rr_d, gkey;
  logic [KW+1:0] head;
  evt_type_t gtype;
  logic gnt, push_rdy, ovf_q, ovf_d;
  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_state_t st_q, st_d;
    logic [TW-1:0] tm_q, tm_d;
    logic [3:0] set_k;
    logic pos, neg;
    // simultaneous rising and falling pulses cancel out
    assign pos = i_pos[k] & ~i_neg[k];
    assign neg = i_neg[k] & ~i_pos[k];
    always_comb begin
      st_d = st_q;
      tm_d = tm_q + 1'b1;
      set_k = '0;
      if (!i_enable) begin
        st_d = KS_IDLE;
        tm_d = '0;
      end else if (st_q == KS_IDLE) begin
        tm_d = '0;
        if (pos) begin
          st_d = KS_HELD;
          set_k[EVT_PRESS] = 1'b1;
        end
      end else if (neg) begin
        st_d = KS_IDLE;
        tm_d = '0;
        set_k[EVT_RELEASE] = 1'b1;
      end else if (st_q == KS_HELD && tm_q == TW'(LONG_CYC - 1)) begin
        st_d = KS_LONG;
        tm_d = '0;
        set_k[EVT_LONG] = 1'b1;
      end else if (st_q == KS_LONG && tm_q == TW'(REPEAT_CYC - 1)) begin
        tm_d = '0;
        set_k[EVT_REPEAT] = 1'b1;
      end
    end
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        st_q <= KS_IDLE;
        tm_q <= '0;
      end else begin
        st_q <= st_d;
        tm_q <= tm_d;
      end
    end
    assign set_e[k] = set_k;
    assign clr_e[k] = (gnt && gkey == KW'(k)) ? 4'b0001 << gtype : 4'b0000;
  end
  // lowest offset from the RR pointer wins; within a key the lowest type index wins
  always_comb begin
    gkey = rr_q;
    for (int i = N_KEYS - 1; i >= 0; i--)
      if (|pend_q[(int'(rr_q) + i) % N_KEYS]) gkey = KW'((int'(rr_q) + i) % N_KEYS);
    gtype = EVT_RELEASE;
    for (int t = 3; t >= 0; t--)
      if (pend_q[gkey][t]) gtype = evt_type_t'(t[1:0]);
    gnt = push_rdy & (|pend_q);
  end
  always_comb begin
    pend_d = (pend_q & ~clr_e) | set_e;
    ovf_d = (ovf_q & ~i_clr_ovf) | (|(set_e & pend_q & ~clr_e));
    rr_d = gnt ? (gkey == KW'(N_KEYS - 1) ? '0 : gkey + 1'b1) : rr_q;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pend_q <= '0;
      rr_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      rr_q <= rr_d;
      ovf_q <= ovf_d;
    end
  end
  key_evt_fifo #(.DEPTH(FIFO_DEPTH), .W(KW + 2)) u_fifo (
    .clk(i_clk),
    .rst(i_rst),
    .push_i(gnt),
    .data_i({gkey, gtype}),
    .ready_i(i_evt_ready),
    .valid_o(o_evt_valid),
    .data_o(head),
    .push_rdy_o(push_rdy)
  );
  assign {o_evt_key, o_evt_type} = head;
  assign o_overflow = ovf_q;
endmodule
